serial_exec_seq: RTL and testbench

- Phase sequencer for the bit-serial (1-bit slice) RV32 datapath.
- Accepts one decoded instruction at a time and walks the slice datapath through execute, memory, writeback and PC-update phases.
- Each bit phase lasts XLEN cycles: one-hot bit select per cycle, carry and compare-chain state held between cycles.
- Sits between the decoder and the slice datapath (ALU, shifter, compare, regfile, PC adder).

---
 rtl/serial_exec_if.sv | 50 +++++
 rtl/serial_exec_seq.sv | 135 +++++++++++++
 tb/tb_serial_exec_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_exec_if.sv
// Bundle between the decoder / 1-bit slice datapath and the phase sequencer.
// The sequencer side uses the slave modport; the decoder/datapath side uses master.
interface serial_exec_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic            op_sub;
  logic            op_cmp;
  logic            op_signed;
  logic            op_branch;
  logic            br_on_lt;
  logic            br_negate;
  logic            op_mem;
  logic            op_wb;
  logic [XLEN-1:0] bit_sel;
  logic            alu_cin;
  logic            alu_cout;
  logic            pc_cin;
  logic            pc_cout;
  logic            cmp_eq_in;
  logic            cmp_lt_in;
  logic            cmp_eq_out;
  logic            cmp_lt_out;
  logic            cmp_swap;
  logic            rf_we;
  logic            wb_cmp;
  logic            cmp_bit;
  logic            pc_en;
  logic            pc_mux_sel;
  logic            mem_req;
  logic            mem_ack;
  logic            done;

  modport master (
    output instr_valid, op_sub, op_cmp, op_signed, op_branch, br_on_lt,
           br_negate, op_mem, op_wb, alu_cout, pc_cout, cmp_eq_out,
           cmp_lt_out, mem_ack,
    input  instr_ready, bit_sel, alu_cin, pc_cin, cmp_eq_in, cmp_lt_in,
           cmp_swap, rf_we, wb_cmp, cmp_bit, pc_en, pc_mux_sel, mem_req, done
  );

  modport slave (
    input  instr_valid, op_sub, op_cmp, op_signed, op_branch, br_on_lt,
           br_negate, op_mem, op_wb, alu_cout, pc_cout, cmp_eq_out,
           cmp_lt_out, mem_ack,
    output instr_ready, bit_sel, alu_cin, pc_cin, cmp_eq_in, cmp_lt_in,
           cmp_swap, rf_we, wb_cmp, cmp_bit, pc_en, pc_mux_sel, mem_req, done
  );
endinterface

// File: rtl/serial_exec_seq.sv
// Phase sequencer for the bit-serial RV32 slice datapath.
// Walks one instruction through EXEC, MEM, LDWB/CMPWB and PCUPD phases,
// each bit phase lasting XLEN cycles with a one-hot slice select.
// Optional macro SERIAL_SEQ_FAST_PC_EN: for non-mem, non-cmp instructions the
// PC update overlaps EXEC and the separate PCUPD phase is skipped.
module serial_exec_seq #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  serial_exec_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {IDLE, EXEC, MEM, LDWB, CMPWB, PCUPD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic          last;
  logic          in_bit;
  logic          fast_pc;
  logic          pc_phase;
  logic          branch_taken;

  logic op_sub_r, op_cmp_r, op_signed_r, op_branch_r;
  logic br_on_lt_r, br_negate_r, op_mem_r, op_wb_r;
  logic alu_c, pc_c, eq_r, lt_r, done_r;

  assign last   = (cnt == LAST);
  assign in_bit = (state == EXEC) || (state == LDWB) ||
                  (state == CMPWB) || (state == PCUPD);
  // Compares scan MSB-first so the sign bit is seen before the magnitude bits.
  assign idx    = (state == EXEC && op_cmp_r) ? (LAST - cnt) : cnt;

`ifdef SERIAL_SEQ_FAST_PC_EN
  assign fast_pc = ~op_mem_r & ~op_cmp_r;
`else
  assign fast_pc = 1'b0;
`endif

  assign pc_phase     = (state == PCUPD) || (state == EXEC && fast_pc);
  // Chains are frozen after EXEC, so this stays constant across PCUPD.
  assign branch_taken = op_branch_r & ((br_on_lt_r ? lt_r : eq_r) ^ br_negate_r);

  // Next-state selection; the counter wrap marks every bit-phase exit.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.instr_valid) state_nx = EXEC;
      EXEC:  if (last) begin
               if (op_mem_r)                 state_nx = MEM;
               else if (op_cmp_r && op_wb_r) state_nx = CMPWB;
               else if (fast_pc)             state_nx = IDLE;
               else                          state_nx = PCUPD;
             end
      MEM:   if (bus.mem_ack) state_nx = op_wb_r ? LDWB : PCUPD;
      LDWB:  if (last) state_nx = PCUPD;
      CMPWB: if (last) state_nx = PCUPD;
      PCUPD: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, slice counter and retire flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= (in_bit && !last) ? cnt + 1'b1 : '0;
      done_r <= (state != IDLE) && (state_nx == IDLE);
    end
  end

  // Decoded fields are captured only at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      {op_sub_r, op_cmp_r, op_signed_r, op_branch_r} <= 4'b0;
      {br_on_lt_r, br_negate_r, op_mem_r, op_wb_r}   <= 4'b0;
    end else if (state == IDLE && bus.instr_valid) begin
      op_sub_r    <= bus.op_sub;
      op_cmp_r    <= bus.op_cmp;
      op_signed_r <= bus.op_signed;
      op_branch_r <= bus.op_branch;
      br_on_lt_r  <= bus.br_on_lt;
      br_negate_r <= bus.br_negate;
      op_mem_r    <= bus.op_mem;
      op_wb_r     <= bus.op_wb;
    end
  end

  // Carry and compare chains: re-seeded at accept, advanced one slice per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_c <= 1'b0;
      pc_c  <= 1'b0;
      eq_r  <= 1'b1;
      lt_r  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.instr_valid) begin
        alu_c <= bus.op_sub;
        pc_c  <= 1'b0;
        eq_r  <= 1'b1;
        lt_r  <= 1'b0;
      end
    end else begin
      if (state == EXEC) begin
        alu_c <= bus.alu_cout;
        eq_r  <= bus.cmp_eq_out;
        lt_r  <= bus.cmp_lt_out;
      end
      if (pc_phase) pc_c <= last ? 1'b0 : bus.pc_cout;
    end
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.bit_sel     = in_bit ? ({{(XLEN-1){1'b0}}, 1'b1} << idx) : '0;
  assign bus.alu_cin     = alu_c;
  assign bus.pc_cin      = pc_c;
  assign bus.cmp_eq_in   = eq_r;
  assign bus.cmp_lt_in   = lt_r;
  assign bus.cmp_swap    = (state == EXEC) && op_cmp_r && op_signed_r && (idx == LAST);
  assign bus.rf_we       = ((state == EXEC) && op_wb_r && !op_mem_r && !op_cmp_r) ||
                           (state == LDWB) || (state == CMPWB);
  assign bus.wb_cmp      = (state == CMPWB);
  assign bus.cmp_bit     = (state == CMPWB) && (cnt == '0) && lt_r;
  assign bus.pc_en       = pc_phase;
  assign bus.pc_mux_sel  = pc_phase && branch_taken;
  assign bus.mem_req     = (state == MEM);
  assign bus.done        = done_r;
endmodule

// File: tb/tb_serial_exec_seq.sv
// Self-checking bench for serial_exec_seq: a small datapath model supplies
// carries and a real MSB-first compare; expected retire cycles go through a queue.
module tb_serial_exec_seq;
  localparam int X  = 32;
  localparam int TR = 160;

  localparam logic [7:0] F_ADD  = 8'b0000_0001;
  localparam logic [7:0] F_SUB  = 8'b1000_0001;
  localparam logic [7:0] F_SLT  = 8'b0110_0001;
  localparam logic [7:0] F_SLTU = 8'b0100_0001;
  localparam logic [7:0] F_BNE  = 8'b0101_0100;
  localparam logic [7:0] F_LOAD = 8'b0000_0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  serial_exec_if #(.XLEN(X)) bus();
  serial_exec_seq #(.XLEN(X)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        drv_alu_cout = 1'b0;
  logic        drv_pc_cout  = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        ai, bi, cx, cy;

  assign bus.alu_cout   = drv_alu_cout;
  assign bus.pc_cout    = drv_pc_cout;
  assign ai             = |(bus.bit_sel & rs1);
  assign bi             = |(bus.bit_sel & rs2);
  assign cx             = bus.cmp_swap ? bi : ai;
  assign cy             = bus.cmp_swap ? ai : bi;
  assign bus.cmp_eq_out = bus.cmp_eq_in & (ai == bi);
  assign bus.cmp_lt_out = bus.cmp_lt_in | (bus.cmp_eq_in & ~cx & cy);

  int exp_q[$];
  int t_acc;
  int done_cyc;
  logic [31:0] tr_bs [TR];
  logic tr_rf [TR], tr_pe [TR], tr_ac [TR], tr_pc [TR], tr_sw [TR];
  logic tr_cb [TR], tr_pm [TR], tr_wc [TR], tr_mr [TR];

  // Reference latency from accept to the retire cycle.
  function automatic int exp_lat(logic [7:0] f, int m);
    int l;
    logic fast;
    l = 1 + X;
    if (f[1]) l += m + (f[0] ? X : 0);
    else if (f[6] && f[0]) l += X;
`ifdef SERIAL_SEQ_FAST_PC_EN
    fast = ~f[1] & ~f[6];
`else
    fast = 1'b0;
`endif
    if (!fast) l += X;
    return l;
  endfunction

  task automatic run_instr(input logic [7:0] f, input int ack_dly);
    int k;
    int mcnt;
    k = 0;
    while (!bus.instr_ready && k < 300) begin @(negedge clk); k++; end
    {bus.op_sub, bus.op_cmp, bus.op_signed, bus.op_branch,
     bus.br_on_lt, bus.br_negate, bus.op_mem, bus.op_wb} = f;
    bus.instr_valid = 1'b1;
    t_acc = cyc;
    exp_q.push_back(cyc + exp_lat(f, ack_dly));
    for (int i = 0; i < TR; i++) begin
      tr_bs[i] = '0; tr_rf[i] = 0; tr_pe[i] = 0; tr_ac[i] = 0; tr_pc[i] = 0;
      tr_sw[i] = 0; tr_cb[i] = 0; tr_pm[i] = 0; tr_wc[i] = 0; tr_mr[i] = 0;
    end
    done_cyc = -1;
    mcnt = 0;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    {bus.op_sub, bus.op_cmp, bus.op_signed, bus.op_branch,
     bus.br_on_lt, bus.br_negate, bus.op_mem, bus.op_wb} = ~f;
    for (int i = 1; i < TR && done_cyc < 0; i++) begin
      tr_bs[i] = bus.bit_sel;  tr_rf[i] = bus.rf_we;    tr_pe[i] = bus.pc_en;
      tr_ac[i] = bus.alu_cin;  tr_pc[i] = bus.pc_cin;   tr_sw[i] = bus.cmp_swap;
      tr_cb[i] = bus.cmp_bit;  tr_pm[i] = bus.pc_mux_sel;
      tr_wc[i] = bus.wb_cmp;   tr_mr[i] = bus.mem_req;
      bus.mem_ack = 1'b0;
      if (bus.done) done_cyc = cyc;
      else begin
        if (bus.mem_req) begin
          mcnt++;
          if (mcnt == ack_dly) bus.mem_ack = 1'b1;
        end else if (i == 3) bus.mem_ack = 1'b1;
        @(negedge clk);
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    {bus.op_sub, bus.op_cmp, bus.op_signed, bus.op_branch,
     bus.br_on_lt, bus.br_negate, bus.op_mem, bus.op_wb} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
    checks++;
    if (bus.bit_sel !== '0) begin errors++; $display("FAIL reset_bit_sel got=%h exp=0", bus.bit_sel); end
    checks++;
    if ({bus.rf_we, bus.pc_en, bus.mem_req, bus.done, bus.wb_cmp, bus.cmp_swap, bus.pc_mux_sel} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=0000000",
               {bus.rf_we, bus.pc_en, bus.mem_req, bus.done, bus.wb_cmp, bus.cmp_swap, bus.pc_mux_sel});
    end
    checks++;
    if ({bus.alu_cin, bus.pc_cin, bus.cmp_eq_in, bus.cmp_lt_in} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_chains got=%b exp=0010", {bus.alu_cin, bus.pc_cin, bus.cmp_eq_in, bus.cmp_lt_in});
    end
  endtask

  task automatic check_done(input string name);
    int e;
    e = exp_q.pop_front();
    checks++;
    if (done_cyc !== e) begin errors++; $display("FAIL %s_done got=%0d exp=%0d", name, done_cyc, e); end
  endtask

  task automatic test_add;
    int bad, ps, npe;
    drv_alu_cout = 1'b1;
    drv_pc_cout  = 1'b1;
    run_instr(F_ADD, 0);
    bad = 0;
    for (int k = 1; k <= X; k++)
      if (tr_bs[k] !== (32'h1 << (k - 1)) || tr_rf[k] !== 1'b1) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL add_exec_walk got=%0d bad exp=0", bad); end
    checks++;
    if ({tr_ac[1], tr_ac[2]} !== 2'b01) begin errors++; $display("FAIL add_alu_cin got=%b exp=01", {tr_ac[1], tr_ac[2]}); end
    ps = exp_lat(F_ADD, 0) - X;
    npe = 0; bad = 0;
    for (int k = 1; k < TR; k++) begin
      if (tr_pe[k]) npe++;
      if (tr_pe[k] !== ((k >= ps) && (k < ps + X))) bad++;
      if (tr_pm[k] !== 1'b0) bad++;
    end
    checks++;
    if (npe !== X || bad !== 0) begin errors++; $display("FAIL add_pc_en got=%0d cycles/%0d bad exp=%0d/0", npe, bad, X); end
    checks++;
    if ({tr_pc[ps], tr_pc[ps + 1]} !== 2'b01) begin errors++; $display("FAIL add_pc_cin got=%b exp=01", {tr_pc[ps], tr_pc[ps + 1]}); end
    check_done("add");
    drv_alu_cout = 1'b0;
    drv_pc_cout  = 1'b0;
  endtask

  task automatic test_sub;
    int bad;
    drv_alu_cout = 1'b1;
    run_instr(F_SUB, 0);
    bad = 0;
    for (int k = 1; k <= X; k++) if (tr_ac[k] !== 1'b1) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sub_alu_cin got=%0d bad exp=0", bad); end
    check_done("sub");
    drv_alu_cout = 1'b0;
  endtask

  task automatic test_compare(input logic [7:0] f, input logic exp_lt, input string name);
    int bad, nsw, nrf, nwc;
    rs1 = 32'hFFFF_FFFF;
    rs2 = 32'h0000_0001;
    run_instr(f, 0);
    checks++;
    if (tr_bs[1] !== 32'h8000_0000 || tr_bs[X] !== 32'h1) begin
      errors++; $display("FAIL %s_order got=%h..%h exp=80000000..00000001", name, tr_bs[1], tr_bs[X]);
    end
    nsw = 0; nrf = 0; nwc = 0; bad = 0;
    for (int k = 1; k < TR; k++) begin
      if (tr_sw[k]) nsw++;
      if (tr_rf[k]) nrf++;
      if (tr_wc[k]) nwc++;
      if (k != X + 1 && tr_cb[k] !== 1'b0) bad++;
    end
    checks++;
    if (nsw !== int'(f[5]) || tr_sw[1] !== f[5]) begin errors++; $display("FAIL %s_swap got=%0d exp=%0d", name, nsw, f[5]); end
    checks++;
    if (tr_cb[X + 1] !== exp_lt || tr_bs[X + 1] !== 32'h1 || bad !== 0) begin
      errors++; $display("FAIL %s_cmp_bit got=%b (%0d stray) exp=%b", name, tr_cb[X + 1], bad, exp_lt);
    end
    checks++;
    if (nrf !== X || nwc !== X || tr_wc[X + 1] !== 1'b1) begin
      errors++; $display("FAIL %s_cmpwb got=rf%0d/wb%0d exp=%0d", name, nrf, nwc, X);
    end
    check_done(name);
  endtask

  task automatic test_branch(input logic [31:0] a, input logic [31:0] b, input logic exp_sel, input string name);
    int bad, ps;
    rs1 = a;
    rs2 = b;
    run_instr(F_BNE, 0);
    ps = exp_lat(F_BNE, 0) - X;
    bad = 0;
    for (int k = 1; k < TR; k++)
      if (tr_pm[k] !== (((k >= ps) && (k < ps + X)) ? exp_sel : 1'b0)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s_pc_mux got=%0d bad cycles exp=0 (sel %b)", name, bad, exp_sel); end
    check_done(name);
  endtask

  task automatic test_load;
    int nmr, nrf, bad;
    run_instr(F_LOAD, 5);
    nmr = 0; nrf = 0; bad = 0;
    for (int k = 1; k < TR; k++) begin
      if (tr_mr[k]) begin nmr++; if (tr_bs[k] !== '0) bad++; end
      if (tr_rf[k]) nrf++;
    end
    checks++;
    if (nmr !== 5 || bad !== 0 || tr_mr[X + 1] !== 1'b1 || tr_mr[X + 5] !== 1'b1) begin
      errors++; $display("FAIL load_mem_req got=%0d cycles/%0d bad exp=5/0", nmr, bad);
    end
    checks++;
    if (nrf !== X || tr_rf[X + 6] !== 1'b1 || tr_rf[2 * X + 5] !== 1'b1 || tr_rf[X + 5] !== 1'b0) begin
      errors++; $display("FAIL load_ldwb got=%0d rf cycles exp=%0d", nrf, X);
    end
    check_done("load");
  endtask

  task automatic test_reset_mid_mem;
    int k, bad;
    k = 0;
    while (!bus.instr_ready && k < 300) begin @(negedge clk); k++; end
    {bus.op_sub, bus.op_cmp, bus.op_signed, bus.op_branch,
     bus.br_on_lt, bus.br_negate, bus.op_mem, bus.op_wb} = F_LOAD;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    k = 0;
    while (!bus.mem_req && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmem_reach got=%b exp=1", bus.mem_req); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL rstmem_drop got=req%b rdy%b done%b exp=req0 rdy1 done0", bus.mem_req, bus.instr_ready, bus.done);
    end
    bad = 0;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.mem_req !== 1'b0 || bus.instr_ready !== 1'b1 || bus.bit_sel !== '0) bad++;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rstmem_idle got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_back_to_back;
    int d1;
    run_instr(F_ADD, 0);
    d1 = done_cyc;
    check_done("b2b_first");
    run_instr(F_ADD, 0);
    checks++;
    if (t_acc !== d1) begin errors++; $display("FAIL b2b_accept got=%0d exp=%0d", t_acc, d1); end
    check_done("b2b_second");
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_compare(F_SLT, 1'b1, "slt");
    test_compare(F_SLTU, 1'b0, "sltu");
    test_branch(32'd5, 32'd4, 1'b1, "bne_taken");
    test_branch(32'd7, 32'd7, 1'b0, "bne_fall");
    test_load;
    test_reset_mid_mem;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
